// File: rtl/vblank_update_scheduler.sv
// vblank_update_scheduler
// Grants game-logic writes into the object-attribute bank only during
// vertical blanking. Requesters are served round-robin, one write per grant,
// with a per-frame write budget. The window closes a few lines before the
// frame wraps so the bank is stable when the next visible frame starts.
module vblank_update_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int V_VISIBLE   = 480,
    parameter int V_TOTAL     = 521,
    parameter int GUARD_LINES = 2,
    parameter int MAX_WRITES  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pix_en,
    input  logic [31:0]                hCount,
    input  logic [31:0]                vCount,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [DATA_W-1:0]          wr_data,
    output logic                       window_open,
    output logic                       frame_tick,
    output logic [7:0]                 missed_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_WRITES + 1);
    localparam logic [31:0] BLANK_LINE = 32'(V_VISIBLE);
    localparam logic [31:0] CLOSE_LINE = 32'(V_TOTAL - GUARD_LINES);
    localparam logic [CNT_W-1:0] BUDGET = CNT_W'(MAX_WRITES);

    typedef enum logic [1:0] {IDLE, ARB, GRANT, CLOSE} stateT;

    stateT             stateReg, stateNext;
    logic [IDX_W-1:0]  ptrReg, ptrNext;
    logic [IDX_W-1:0]  winReg, winNext;
    logic [IDX_W-1:0]  winSel;
    logic [CNT_W-1:0]  wrCntReg, wrCntNext;
    logic [ADDR_W-1:0] addrReg, addrNext;
    logic [DATA_W-1:0] dataReg, dataNext;
    logic              frameTickReg, frameTickNext;
    logic [7:0]        missedReg, missedNext;
    logic              blankStart;
    logic              closeCond;
    int                scanIdx;
    logic              scanFound;

    logic [ADDR_W-1:0] reqAddrArr [NUM_REQ];
    logic [DATA_W-1:0] reqDataArr [NUM_REQ];

    // Unpack the flattened requester buses into per-requester words.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign reqAddrArr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign reqDataArr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign blankStart = pix_en && (vCount == BLANK_LINE) && (hCount == 32'd0);
    assign closeCond  = (vCount >= CLOSE_LINE) || (wrCntReg == BUDGET);

    // Round-robin pick: first requesting index at or above ptr, wrapping.
    always_comb begin
        winSel    = '0;
        scanFound = 1'b0;
        scanIdx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scanIdx = int'(ptrReg) + k;
            if (scanIdx >= NUM_REQ) begin
                scanIdx = scanIdx - NUM_REQ;
            end
            if (!scanFound && req[scanIdx]) begin
                scanFound = 1'b1;
                winSel    = IDX_W'(scanIdx);
            end
        end
    end

    // Next-state logic for the blanking-window sequencer.
    always_comb begin
        stateNext     = stateReg;
        ptrNext       = ptrReg;
        winNext       = winReg;
        wrCntNext     = wrCntReg;
        addrNext      = addrReg;
        dataNext      = dataReg;
        frameTickNext = 1'b0;
        missedNext    = missedReg;
        case (stateReg)
            IDLE: begin
                if (blankStart) begin
                    frameTickNext = 1'b1;
                    wrCntNext     = '0;
                    stateNext     = ARB;
                end
            end
            ARB: begin
                if (closeCond) begin
                    stateNext = CLOSE;
                end else if (|req) begin
                    winNext   = winSel;
                    addrNext  = reqAddrArr[winSel];
                    dataNext  = reqDataArr[winSel];
                    stateNext = GRANT;
                end
            end
            GRANT: begin
                // The grant always finishes; closing is decided back in ARB.
                ptrNext   = (winReg == IDX_W'(NUM_REQ - 1)) ? '0 : winReg + IDX_W'(1);
                wrCntNext = wrCntReg + CNT_W'(1);
                stateNext = ARB;
            end
            CLOSE: begin
                if ((|req) && (missedReg != 8'hFF)) begin
                    missedNext = missedReg + 8'd1;
                end
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stateReg     <= IDLE;
            ptrReg       <= '0;
            winReg       <= '0;
            wrCntReg     <= '0;
            addrReg      <= '0;
            dataReg      <= '0;
            frameTickReg <= 1'b0;
            missedReg    <= '0;
        end else begin
            stateReg     <= stateNext;
            ptrReg       <= ptrNext;
            winReg       <= winNext;
            wrCntReg     <= wrCntNext;
            addrReg      <= addrNext;
            dataReg      <= dataNext;
            frameTickReg <= frameTickNext;
            missedReg    <= missedNext;
        end
    end

    // One-hot grant to the latched winner while in GRANT.
    always_comb begin
        gnt = '0;
        if (stateReg == GRANT) begin
            gnt[winReg] = 1'b1;
        end
    end

    assign wr_en       = (stateReg == GRANT);
    assign wr_addr     = addrReg;
    assign wr_data     = dataReg;
    assign window_open = (stateReg == ARB) || (stateReg == GRANT);
    assign frame_tick  = frameTickReg;
    assign missed_cnt  = missedReg;

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Self-checking bench for vblank_update_scheduler. Expected writes are queued
// when stimulus is set up and compared whenever the DUT strobes wr_en.
module tb_vblank_update_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic         pix_en;
    logic [31:0]  hCount;
    logic [31:0]  vCount;
    logic [3:0]   req;
    logic [19:0]  req_addr;
    logic [127:0] req_data;
    logic [3:0]   gnt;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         window_open;
    logic         frame_tick;
    logic [7:0]   missed_cnt;

    int checks = 0;
    int errors = 0;
    int wrSeen = 0;

    typedef struct {
        logic [3:0]  g;
        logic [4:0]  a;
        logic [31:0] d;
    } expT;
    expT sbQ[$];

    always #5 clk = ~clk;

    vblank_update_scheduler dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hCount(hCount), .vCount(vCount),
        .req(req), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .window_open(window_open), .frame_tick(frame_tick), .missed_cnt(missed_cnt)
    );

    // Advance one cycle, sample on the falling edge and score any write.
    task automatic tick();
        expT e;
        @(negedge clk);
        checks++;
        if (wr_en === 1'b1) begin
            wrSeen++;
            if (sbQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got gnt=%b addr=%0d data=%h, required no write",
                         gnt, wr_addr, wr_data);
            end else begin
                e = sbQ.pop_front();
                if (gnt !== e.g || wr_addr !== e.a || wr_data !== e.d) begin
                    errors++;
                    $display("FAIL write_content: got gnt=%b addr=%0d data=%h, required gnt=%b addr=%0d data=%h",
                             gnt, wr_addr, wr_data, e.g, e.a, e.d);
                end else begin
                    $display("write gnt=%b addr=%0d data=%h", gnt, wr_addr, wr_data);
                end
            end
        end else if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL gnt_without_wr_en: got gnt=%b, required 0000", gnt);
        end
    endtask

    task automatic setReq(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[i*5 +: 5]   = a;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic pushExp(input int i, input logic [4:0] a, input logic [31:0] d);
        expT e;
        e.g = 4'(1 << i);
        e.a = a;
        e.d = d;
        sbQ.push_back(e);
    endtask

    task automatic checkVal(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // Drive the window shut at the guard line and let CLOSE/IDLE run.
    task automatic closeWindow();
        vCount = 32'd519;
        hCount = 32'd5;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; pix_en = 1'b0; hCount = 0; vCount = 0; req = 4'b0;
        req_addr = '0; req_data = '0;
        repeat (3) tick();
        checkVal("reset_outputs_zero",
                 int'({gnt, wr_en, wr_addr, window_open, frame_tick, missed_cnt} != '0 || wr_data != 0), 0);
        rst = 1'b1;
        tick();
        checkVal("reset_release_closed", int'(window_open), 0);
    endtask

    task automatic test_first_frame();
        int n0, ft, firstT, lastT, spacingBad, openSeen;
        for (int i = 0; i < 4; i++) setReq(i, 5'(10 + i), 32'hA000_0000 + i);
        pix_en = 1'b1; vCount = 32'd100; hCount = 0; req = 4'b1111;
        n0 = wrSeen; openSeen = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            hCount = 32'(t + 1);
            openSeen += int'(window_open);
        end
        checkVal("active_no_writes", wrSeen - n0, 0);
        checkVal("active_window_closed", openSeen, 0);
        for (int i = 0; i < 4; i++) pushExp(i, 5'(10 + i), 32'hA000_0000 + i);
        vCount = 32'd480; hCount = 0;
        ft = 0; firstT = -1; lastT = -1; spacingBad = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (t == 0) hCount = 32'd1;
            ft += int'(frame_tick);
            if (wr_en === 1'b1) begin
                if (lastT >= 0 && t - lastT != 2) spacingBad++;
                if (firstT < 0) firstT = t;
                lastT = t;
                req = req & ~gnt;
            end
        end
        checkVal("frame_tick_pulses", ft, 1);
        checkVal("first_grant_cycle", firstT, 1);
        checkVal("grant_spacing_errors", spacingBad, 0);
        checkVal("first_frame_writes", wrSeen - n0, 4);
        checkVal("window_open_idle_arb", int'(window_open), 1);
        closeWindow();
        checkVal("window_closed_after", int'(window_open), 0);
        checkVal("missed_after_clean_close", int'(missed_cnt), 0);
    endtask

    task automatic test_budget();
        int n0;
        setReq(0, 5'd3, 32'h1111_0000);
        setReq(2, 5'd9, 32'h2222_0000);
        req = 4'b0101;
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 0) pushExp(0, 5'd3, 32'h1111_0000);
            else            pushExp(2, 5'd9, 32'h2222_0000);
        end
        n0 = wrSeen;
        vCount = 32'd480; hCount = 0;
        for (int t = 0; t < 50; t++) begin
            tick();
            if (t == 0) hCount = 32'd1;
        end
        checkVal("budget_writes", wrSeen - n0, 16);
        checkVal("budget_window_closed", int'(window_open), 0);
        checkVal("budget_missed", int'(missed_cnt), 1);
        req = 4'b0;
        vCount = 32'd520;
        tick();
    endtask

    task automatic test_single();
        int n0;
        setReq(1, 5'd7, 32'hDEADBEEF);
        req = 4'b0010;
        pushExp(1, 5'd7, 32'hDEADBEEF);
        n0 = wrSeen;
        vCount = 32'd480; hCount = 0;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (t == 0) hCount = 32'd1;
            if (wr_en === 1'b1) req = req & ~gnt;
        end
        checkVal("single_writes", wrSeen - n0, 1);
        checkVal("single_addr_held", int'(wr_addr), 7);
        checkVal("single_data_held", int'(wr_data == 32'hDEADBEEF), 1);
        closeWindow();
        checkVal("single_missed_unchanged", int'(missed_cnt), 1);
    endtask

    task automatic test_line_close();
        int n0, k, openSeen;
        setReq(0, 5'd4, 32'h0BADF00D);
        req = 4'b0001;
        for (int i = 0; i < 3; i++) pushExp(0, 5'd4, 32'h0BADF00D);
        n0 = wrSeen;
        vCount = 32'd480; hCount = 0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (t == 0) hCount = 32'd1;
            k = wrSeen - n0;
            if (wr_en === 1'b1 && k == 2) vCount = 32'd518;
            if (wr_en === 1'b1 && k == 3) vCount = 32'd519;
        end
        checkVal("line_close_writes", wrSeen - n0, 3);
        checkVal("line_close_window", int'(window_open), 0);
        checkVal("line_close_missed", int'(missed_cnt), 2);
        vCount = 32'd520;
        tick();
        n0 = wrSeen; openSeen = 0;
        for (int v = 0; v < 480; v++) begin
            vCount = 32'(v); hCount = 0;
            tick();
            openSeen += int'(window_open);
        end
        checkVal("next_frame_active_writes", wrSeen - n0, 0);
        checkVal("next_frame_active_open", openSeen, 0);
        req = 4'b0;
    endtask

    task automatic test_reset_mid_grant();
        int n0, openSeen;
        bit hit;
        setReq(3, 5'd21, 32'hCAFE0003);
        req = 4'b1000;
        pushExp(3, 5'd21, 32'hCAFE0003);
        vCount = 32'd480; hCount = 0;
        hit = 1'b0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (t == 0) hCount = 32'd1;
            if (wr_en === 1'b1) begin
                rst = 1'b0;
                hit = 1'b1;
                break;
            end
        end
        checkVal("mid_grant_reached", int'(hit), 1);
        tick();
        checkVal("mid_grant_reset_zero",
                 int'({gnt, wr_en, wr_addr, window_open, frame_tick, missed_cnt} != '0 || wr_data != 0), 0);
        vCount = 32'd490;
        tick();
        rst = 1'b1;
        n0 = wrSeen; openSeen = 0;
        for (int t = 0; t < 20; t++) begin
            vCount = 32'(490 + t); hCount = 0;
            tick();
            openSeen += int'(window_open);
        end
        vCount = 32'd0;
        repeat (3) tick();
        checkVal("post_reset_no_window", openSeen, 0);
        checkVal("post_reset_no_writes", wrSeen - n0, 0);
        pushExp(3, 5'd21, 32'hCAFE0003);
        n0 = wrSeen; openSeen = 0;
        vCount = 32'd480; hCount = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (t == 0) hCount = 32'd1;
            openSeen += int'(window_open);
            if (wr_en === 1'b1) req = req & ~gnt;
        end
        checkVal("post_reset_frame_writes", wrSeen - n0, 1);
        checkVal("post_reset_frame_open", int'(openSeen > 0), 1);
        closeWindow();
        checkVal("post_reset_missed", int'(missed_cnt), 0);
    endtask

    task automatic test_saturation();
        int n0;
        setReq(0, 5'd1, 32'h5A5A_0001);
        req = 4'b0001;
        n0 = wrSeen;
        for (int f = 0; f < 300; f++) begin
            pix_en = 1'b1; vCount = 32'd480; hCount = 0;
            tick();
            hCount = 32'd1; vCount = 32'd519;
            repeat (3) tick();
            if (f == 99) checkVal("missed_at_100", int'(missed_cnt), 100);
        end
        checkVal("missed_saturated", int'(missed_cnt), 255);
        checkVal("saturation_no_writes", wrSeen - n0, 0);
        req = 4'b0;
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_budget();
        test_single();
        test_line_close();
        test_reset_mid_grant();
        test_saturation();
        checkVal("scoreboard_drained", sbQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vblank_update_scheduler.md
Name: vblank_update_scheduler

Overview:
- Arbitrates game-logic writes (player, scroll and wall object attributes) into the shared object-attribute register bank that drives the display compare logic.
- Writes are only granted during vertical blanking, so object position and size values never change mid-frame.
- Up to NUM_REQ requesters are served round-robin, one write per grant, with a per-frame write budget.
- Sits between the game-state logic and the attribute bank; timing is taken from the existing hCount/vCount counters.

Parameters:
- NUM_REQ, 4, number of requesters.
- ADDR_W, 5, attribute-bank word address width.
- DATA_W, 32, attribute data width.
- V_VISIBLE, 480, first blanking line number.
- V_TOTAL, 521, total lines per frame.
- GUARD_LINES, 2, lines before V_TOTAL at which the write window closes.
- MAX_WRITES, 16, maximum grants per frame.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-low.
- pix_en, input, 1: pixel-rate strobe; hCount/vCount are valid and advance when high.
- hCount, input, 32: current horizontal pixel count.
- vCount, input, 32: current line count.
- req, input, NUM_REQ: per-requester write request (level).
- req_addr, input, NUM_REQ*ADDR_W: flattened addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data, input, NUM_REQ*DATA_W: flattened data; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt, output, NUM_REQ: one-hot grant, 1-cycle pulse.
- wr_en, output, 1: attribute-bank write strobe.
- wr_addr, output, ADDR_W: attribute-bank write address.
- wr_data, output, DATA_W: attribute-bank write data.
- window_open, output, 1: high while writes are permitted.
- frame_tick, output, 1: 1-cycle pulse at blank start.
- missed_cnt, output, 8: saturating count of frames that ended with requests still pending.

Behaviour:
- Reset:
  - Applies when rst==0 at a clk edge.
  - All outputs go to 0, the round-robin pointer to 0, the write counter to 0, and the state to IDLE.
- Blank start event: pix_en && vCount==V_VISIBLE && hCount==0.
- Close condition: vCount >= V_TOTAL-GUARD_LINES, or grants this frame == MAX_WRITES.
- States IDLE, ARB, GRANT, CLOSE:
  - IDLE: window_open=0. On blank start: frame_tick=1 (registered, next cycle), write counter cleared, go to ARB.
    - Leaving reset during blanking does not open a window; the block waits for the next blank start.
  - ARB: window_open=1.
    - If close condition is true, go to CLOSE.
    - Else if req!=0, pick the winner w: the first set bit scanning from ptr upward, wrapping modulo NUM_REQ. Latch req_addr[w] and req_data[w], then go to GRANT.
    - Else stay in ARB.
  - GRANT: gnt[w]=1, wr_en=1, wr_addr/wr_data = latched values, all for exactly 1 cycle.
    - Update: ptr = (w+1) mod NUM_REQ; write counter +1; go to ARB.
    - A grant in progress always completes, even if the close condition becomes true during it.
  - CLOSE: window_open=0. If req!=0 this cycle, missed_cnt increments (saturates at 255). Go to IDLE.
- Throughput: 2 cycles per write (ARB, GRANT). There are no wait states while requests are pending.
- Requester protocol:
  - The requester holds req, addr and data stable until it sees its gnt.
  - It deasserts req the cycle after gnt, or keeps it high to request another write.
  - Dropping req before gnt is legal; that request is simply not served.
- Outside GRANT: gnt=0, wr_en=0, and wr_addr/wr_data hold their last values.
- Simultaneous events:
  - If a blank start occurs while not in IDLE (only possible with invalid timing inputs), it is ignored.
  - If several requests arrive in the same cycle, each is served in pointer order, one per grant.
- The write counter is $clog2(MAX_WRITES+1) bits wide. Comparisons against vCount are unsigned 32-bit.

Test Plan:
- Reset, then vCount=100, req=4'b1111 → no gnt or wr_en, window_open=0; at vCount=480, hCount=0, pix_en=1 → frame_tick pulses once, and gnts arrive in order 0,1,2,3, spaced 2 cycles apart.
- req0 and req2 held high through one window, with ptr=0 → grant order 0,2,0,2…, stopping after exactly 16 wr_en pulses; CLOSE sees req!=0, so missed_cnt=1.
- Single requester 1 with addr=5'd7, data=32'hDEADBEEF → exactly 1 wr_en with wr_addr=7, wr_data=DEADBEEF, gnt=4'b0010, no further writes.
- Hold req0 continuously until vCount=519 → the window closes at line 519, and an in-flight GRANT still completes; no wr_en occurs in the following frame's active lines (vCount 0–479).
- Drive rst=0 mid-GRANT → the next cycle all outputs are 0; releasing reset at vCount=490 opens no window until the next frame's line 480.
- 300 consecutive frames with a pending request at close → missed_cnt saturates at 255.
